// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : T-state sequencer and microcode decoder for the 8-bit CPU,
//               producing the 16-bit control word and owning the halt state.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int STEP_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic [3:0]        opcode,
    input  logic              carry_flag,
    input  logic              zero_flag,
    output logic [15:0]       ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    localparam logic [STEP_W-1:0] c_T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] c_T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] c_T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] c_T3 = STEP_W'(3);
    localparam logic [STEP_W-1:0] c_T4 = STEP_W'(4);

    localparam logic [3:0] c_OP_LDA = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0011;
    localparam logic [3:0] c_OP_STA = 4'b0100;
    localparam logic [3:0] c_OP_LDI = 4'b0101;
    localparam logic [3:0] c_OP_JMP = 4'b0110;
    localparam logic [3:0] c_OP_JC  = 4'b0111;
    localparam logic [3:0] c_OP_JZ  = 4'b1000;
    localparam logic [3:0] c_OP_OUT = 4'b1110;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    localparam logic [15:0] c_HLT = 16'h8000;
    localparam logic [15:0] c_MI  = 16'h4000;
    localparam logic [15:0] c_RI  = 16'h2000;
    localparam logic [15:0] c_RO  = 16'h1000;
    localparam logic [15:0] c_IO  = 16'h0800;
    localparam logic [15:0] c_II  = 16'h0400;
    localparam logic [15:0] c_AI  = 16'h0200;
    localparam logic [15:0] c_AO  = 16'h0100;
    localparam logic [15:0] c_EO  = 16'h0080;
    localparam logic [15:0] c_SU  = 16'h0040;
    localparam logic [15:0] c_BI  = 16'h0020;
    localparam logic [15:0] c_OI  = 16'h0010;
    localparam logic [15:0] c_CE  = 16'h0008;
    localparam logic [15:0] c_CO  = 16'h0004;
    localparam logic [15:0] c_J   = 16'h0002;
    localparam logic [15:0] c_FI  = 16'h0001;

    logic [STEP_W-1:0] r_step;
    logic              r_halted;
    logic [STEP_W-1:0] w_step_nxt;
    logic              w_halted_nxt;
    logic [STEP_W-1:0] w_last_step;
    logic [15:0]       w_ctrl;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_step   <= c_T0;
            r_halted <= 1'b0;
        end else begin
            r_step   <= w_step_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // NOP and undefined opcodes end at T2 because the IR is only valid from T2.
    always_comb begin
        w_last_step = c_T2;
        case (opcode)
            c_OP_LDA, c_OP_STA: w_last_step = c_T3;
            c_OP_ADD, c_OP_SUB: w_last_step = c_T4;
            default:            w_last_step = c_T2;
        endcase
    end

    always_comb begin
        w_step_nxt   = r_step;
        w_halted_nxt = r_halted;
        if (!r_halted && run) begin
            if (r_step > c_T4) begin
                w_step_nxt = c_T0;
            end else if (r_step == c_T0 || r_step == c_T1) begin
                w_step_nxt = r_step + STEP_W'(1);
            end else if (opcode == c_OP_HLT) begin
                w_halted_nxt = 1'b1;
                w_step_nxt   = c_T0;
            end else if (r_step >= w_last_step) begin
                w_step_nxt = c_T0;
            end else begin
                w_step_nxt = r_step + STEP_W'(1);
            end
        end
    end

    always_comb begin
        w_ctrl = 16'h0000;
        if (clr || (!r_halted && !run)) begin
            w_ctrl = 16'h0000;
        end else if (r_halted) begin
            w_ctrl = c_HLT;
        end else begin
            case (r_step)
                c_T0: w_ctrl = c_CO | c_MI;
                c_T1: w_ctrl = c_RO | c_II | c_CE;
                c_T2: begin
                    case (opcode)
                        c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: w_ctrl = c_IO | c_MI;
                        c_OP_LDI: w_ctrl = c_IO | c_AI;
                        c_OP_JMP: w_ctrl = c_IO | c_J;
                        c_OP_JC:  w_ctrl = carry_flag ? (c_IO | c_J) : 16'h0000;
                        c_OP_JZ:  w_ctrl = zero_flag  ? (c_IO | c_J) : 16'h0000;
                        c_OP_OUT: w_ctrl = c_AO | c_OI;
                        c_OP_HLT: w_ctrl = c_HLT;
                        default:  w_ctrl = 16'h0000;
                    endcase
                end
                c_T3: begin
                    case (opcode)
                        c_OP_LDA:           w_ctrl = c_RO | c_AI;
                        c_OP_ADD, c_OP_SUB: w_ctrl = c_RO | c_BI;
                        c_OP_STA:           w_ctrl = c_AO | c_RI;
                        default:            w_ctrl = 16'h0000;
                    endcase
                end
                c_T4: begin
                    case (opcode)
                        c_OP_ADD: w_ctrl = c_EO | c_AI | c_FI;
                        c_OP_SUB: w_ctrl = c_EO | c_AI | c_SU | c_FI;
                        default:  w_ctrl = 16'h0000;
                    endcase
                end
                default: w_ctrl = 16'h0000;
            endcase
        end
    end

    assign ctrl   = w_ctrl;
    assign step   = r_step;
    assign halted = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed and randomized bench for control_sequencer against a
//               microcode-table reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic        run;
    logic [3:0]  opcode;
    logic        carry_flag;
    logic        zero_flag;
    logic [15:0] ctrl;
    logic [2:0]  step;
    logic        halted;

    int n_checks;
    int n_pass;
    int m_step;
    bit m_halted;

    control_sequencer #(.STEP_W(3)) dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .opcode     (opcode),
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag),
        .ctrl       (ctrl),
        .step       (step),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", tag, got, exp, $time);
    endtask

    // Execute micro-steps per opcode, T2 first, packed as {T2,T3,T4}.
    function automatic logic [47:0] exec_words(input logic [3:0] op, input bit c, input bit z);
        case (op)
            4'h1:    return {16'h4800, 16'h1200, 16'h0000};
            4'h2:    return {16'h4800, 16'h1020, 16'h0281};
            4'h3:    return {16'h4800, 16'h1020, 16'h02C1};
            4'h4:    return {16'h4800, 16'h2100, 16'h0000};
            4'h5:    return {16'h0A00, 32'h0};
            4'h6:    return {16'h0802, 32'h0};
            4'h7:    return {(c ? 16'h0802 : 16'h0000), 32'h0};
            4'h8:    return {(z ? 16'h0802 : 16'h0000), 32'h0};
            4'hE:    return {16'h0110, 32'h0};
            4'hF:    return {16'h8000, 32'h0};
            default: return 48'h0;
        endcase
    endfunction

    function automatic int exec_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 2;
            4'h2, 4'h3: return 3;
            default:    return 1;
        endcase
    endfunction

    function automatic logic [15:0] model_ctrl();
        logic [47:0] w;
        if (clr) return 16'h0000;
        if (m_halted) return 16'h8000;
        if (!run) return 16'h0000;
        if (m_step == 0) return 16'h4004;
        if (m_step == 1) return 16'h1408;
        if (m_step - 2 >= exec_len(opcode)) return 16'h0000;
        w = exec_words(opcode, carry_flag, zero_flag);
        return w[47 - 16*(m_step-2) -: 16];
    endfunction

    task automatic model_edge();
        if (clr) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (!m_halted && run) begin
            if (m_step <= 1) m_step++;
            else if (opcode == 4'hF) begin
                m_halted = 1'b1;
                m_step   = 0;
            end else if (m_step - 1 >= exec_len(opcode)) m_step = 0;
            else m_step++;
        end
    endtask

    // One clock: drive at negedge, check model (and optional literal), advance.
    task automatic cycle(input bit c_clr, input bit c_run, input logic [3:0] op,
                         input bit cf, input bit zf, input int lit);
        clr = c_clr; run = c_run; opcode = op; carry_flag = cf; zero_flag = zf;
        #1;
        check("ctrl", ctrl, model_ctrl());
        check("step", {13'h0, step}, 16'(m_step));
        check("halted", {15'h0, halted}, {15'h0, m_halted});
        if (lit >= 0) check("ctrl_lit", ctrl, lit[15:0]);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [3:0] op, input bit cf, input bit zf,
                             input int w2, input int w3, input int w4);
        cycle(0, 1, op, cf, zf, 32'h4004);
        cycle(0, 1, op, cf, zf, 32'h1408);
        cycle(0, 1, op, cf, zf, w2);
        if (w3 >= 0) cycle(0, 1, op, cf, zf, w3);
        if (w4 >= 0) cycle(0, 1, op, cf, zf, w4);
    endtask

    initial begin
        logic [3:0] r_op;
        n_checks = 0; n_pass = 0;
        clr = 1'b1; run = 1'b0; opcode = 4'h0; carry_flag = 1'b0; zero_flag = 1'b0;
        m_step = 0; m_halted = 1'b0;
        @(posedge clk);
        @(negedge clk);

        cycle(1, 0, 4'h0, 0, 0, 32'h0000);
        run_instr(4'h1, 0, 0, 32'h4800, 32'h1200, -1);
        run_instr(4'h2, 0, 0, 32'h4800, 32'h1020, 32'h0281);
        run_instr(4'h3, 0, 0, 32'h4800, 32'h1020, 32'h02C1);
        run_instr(4'h7, 1, 0, 32'h0802, -1, -1);
        run_instr(4'h7, 0, 1, 32'h0000, -1, -1);
        run_instr(4'h8, 0, 1, 32'h0802, -1, -1);
        run_instr(4'hA, 1, 1, 32'h0000, -1, -1);
        run_instr(4'h5, 0, 0, 32'h0A00, -1, -1);
        run_instr(4'hE, 0, 0, 32'h0110, -1, -1);

        // STA paused at T3
        cycle(0, 1, 4'h4, 0, 0, 32'h4004);
        cycle(0, 1, 4'h4, 0, 0, 32'h1408);
        cycle(0, 1, 4'h4, 0, 0, 32'h4800);
        for (int i = 0; i < 4; i++) cycle(0, 0, 4'h4, 0, 0, 32'h0000);
        cycle(0, 1, 4'h4, 0, 0, 32'h2100);
        cycle(0, 1, 4'h4, 0, 0, 32'h4004);
        cycle(0, 1, 4'h4, 0, 0, 32'h1408);

        // Finish that STA, then HLT and sit halted with run toggling
        cycle(0, 1, 4'h4, 0, 0, 32'h4800);
        cycle(0, 1, 4'h4, 0, 0, 32'h2100);
        run_instr(4'hF, 0, 0, 32'h8000, -1, -1);
        for (int i = 0; i < 10; i++) cycle(0, bit'(i % 2), 4'(i), bit'(i % 3 == 0), 1'b1, 32'h8000);
        cycle(1, 1, 4'hF, 0, 0, 32'h0000);
        cycle(0, 1, 4'h2, 0, 0, 32'h4004);

        // clr at ADD T3
        cycle(0, 1, 4'h2, 0, 0, 32'h1408);
        cycle(0, 1, 4'h2, 0, 0, 32'h4800);
        cycle(1, 1, 4'h2, 0, 0, 32'h0000);
        cycle(0, 1, 4'h2, 0, 0, 32'h4004);

        // Randomized run; the opcode only changes at T1, as the IR would.
        r_op = 4'h1;
        for (int i = 0; i < 4000; i++) begin
            bit c_clr;
            if (m_step == 1) begin
                r_op = 4'($urandom_range(0, 15));
                if (r_op == 4'hF && ($urandom % 4) != 0) r_op = 4'h2;
            end
            c_clr = m_halted ? (($urandom % 6) == 0) : (($urandom % 50) == 0);
            cycle(c_clr, ($urandom % 8) != 0, r_op, bit'($urandom % 2), bit'($urandom % 2), -1);
            if (c_clr) r_op = 4'($urandom_range(0, 14));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
